// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction-write path: the loader FSM state
// encoding and the word/line geometry. The ISA buffer and the CPU fetch unit
// use the same geometry constants.
// No ports (package).
// -----------------------------------------------------------------------------
package isa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_DONE    = 2'd3
    } isa_state_e;

    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int ISA_WORD_W = 32;
    localparam int ISA_LINE_W = LINE_WORDS * ISA_WORD_W;

endpackage

// File: rtl/isa_line_packer.sv
// -----------------------------------------------------------------------------
// isa_line_packer
// Four-lane word register with a lane index. Each load writes the word into
// the lane selected by the index and advances it; the index wraps naturally
// after the last lane, so a new line starts at lane 0 without an explicit
// clear.
// Ports:
//   clk_i    write-side clock
//   rstn     asynchronous active-low reset
//   i_clear  drop any partial line (lanes and index to 0)
//   i_load   accept i_word into the current lane
//   i_word   instruction word
//   o_line   packed lanes, lane 0 in the least-significant word
//   o_full   this load fills the last lane (line complete)
// -----------------------------------------------------------------------------
module isa_line_packer
    import isa_pkg::*;
#(
    parameter int WORD_W = ISA_WORD_W
) (
    input  logic                         clk_i,
    input  logic                         rstn,
    input  logic                         i_clear,
    input  logic                         i_load,
    input  logic [WORD_W-1:0]            i_word,
    output logic [LINE_WORDS*WORD_W-1:0] o_line,
    output logic                         o_full
);

    logic [IDX_W-1:0]                   r_idx;
    logic [LINE_WORDS-1:0][WORD_W-1:0]  r_lanes;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_idx   <= '0;
            r_lanes <= '0;
        end else if (i_clear) begin
            r_idx   <= '0;
            r_lanes <= '0;
        end else if (i_load) begin
            r_lanes[r_idx] <= i_word;
            r_idx          <= r_idx + IDX_W'(1);
        end
    end

    assign o_line = r_lanes;
    assign o_full = i_load && (r_idx == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/isa_loader_128.sv
// -----------------------------------------------------------------------------
// isa_loader_128
// Packs a valid/ready stream of 32-bit instruction words into 128-bit lines
// and writes them, one strobe per line, to the cross-clock ISA buffer at an
// auto-incrementing line address. The buffer's full flag stalls emission.
// Ports:
//   clk_i, rstn                  clock, asynchronous active-low reset
//   cfg_start, cfg_abort         start (idle only) / cancel (any state) pulses
//   cfg_base_addr, cfg_len       first line address, number of lines
//   word_valid/word_data/word_ready   input word handshake
//   isa_full_i                   downstream full, sampled only while emitting
//   isa_data_o/isa_wren_o/isa_addr_o  registered line write (data/addr 0 when idle)
//   busy_o                       load in progress
//   done_o                       one-cycle completion pulse
// -----------------------------------------------------------------------------
module isa_loader_128
    import isa_pkg::*;
#(
    parameter int WORD_W    = ISA_WORD_W,
    parameter int LINE_W    = ISA_LINE_W,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk_i,
    input  logic              rstn,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    input  logic              isa_full_i,
    output logic [LINE_W-1:0] isa_data_o,
    output logic              isa_wren_o,
    output logic [ADDR_W-1:0] isa_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    isa_state_e          r_state;
    isa_state_e          w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_remain;
    logic                r_wren;
    logic [LINE_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_addr_o;

    logic                w_load;
    logic                w_clear;
    logic                w_emit;
    logic                w_latch;
    logic                w_line_full;
    logic [LINE_W-1:0]   w_line;

    // A word arriving together with an abort is dropped with the partial line.
    assign w_load = (r_state == ST_COLLECT) && word_valid && !cfg_abort;

    isa_line_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk_i   (clk_i),
        .rstn    (rstn),
        .i_clear (w_clear),
        .i_load  (w_load),
        .i_word  (word_data),
        .o_line  (w_line),
        .o_full  (w_line_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_emit      = 1'b0;
        w_latch     = 1'b0;
        if (cfg_abort) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        w_clear     = 1'b1;
                        w_latch     = 1'b1;
                        w_state_nxt = (cfg_len == '0) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_line_full) begin
                        w_state_nxt = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (!isa_full_i) begin
                        w_emit      = 1'b1;
                        w_state_nxt = (r_remain == LEN_W'(1)) ? ST_DONE : ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write port is registered; data and address are forced to 0 outside the strobe.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_wren   <= 1'b0;
            r_data   <= '0;
            r_addr_o <= '0;
        end else begin
            r_wren   <= w_emit;
            r_data   <= w_emit ? w_line : '0;
            r_addr_o <= w_emit ? r_addr : '0;
            if (w_latch) begin
                r_addr   <= cfg_base_addr;
                r_remain <= cfg_len;
            end else if (w_emit) begin
                r_addr   <= r_addr + ADDR_W'(ADDR_STEP);
                r_remain <= r_remain - LEN_W'(1);
            end
        end
    end

    assign isa_wren_o = r_wren;
    assign isa_data_o = r_data;
    assign isa_addr_o = r_addr_o;
    assign word_ready = (r_state == ST_COLLECT);
    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = (r_state == ST_DONE);

endmodule

// File: tb/tb_isa_loader_128.sv
// -----------------------------------------------------------------------------
// tb_isa_loader_128
// Self-checking bench for isa_loader_128. The reference model treats a load
// as "every four accepted words form one line, written at base + line index";
// expected writes are queued and matched in order against the DUT strobes.
// -----------------------------------------------------------------------------
module tb_isa_loader_128;

    logic         clk_i = 1'b0;
    logic         rstn = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_abort = 1'b0;
    logic [31:0]  cfg_base_addr = '0;
    logic [15:0]  cfg_len = '0;
    logic         word_valid = 1'b0;
    logic [31:0]  word_data = '0;
    logic         word_ready;
    logic         isa_full_i = 1'b0;
    logic [127:0] isa_data_o;
    logic         isa_wren_o;
    logic [31:0]  isa_addr_o;
    logic         busy_o;
    logic         done_o;

    isa_loader_128 dut (
        .clk_i         (clk_i),
        .rstn          (rstn),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_base_addr (cfg_base_addr),
        .cfg_len       (cfg_len),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_ready    (word_ready),
        .isa_full_i    (isa_full_i),
        .isa_data_o    (isa_data_o),
        .isa_wren_o    (isa_wren_o),
        .isa_addr_o    (isa_addr_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wren_cnt = 0;
    int done_cnt = 0;
    int acc_cyc  = 0;
    bit rnd_full = 1'b0;
    bit ready_seen = 1'b0;
    bit prev_done = 1'b0;
    int wren_cyc_q[$];

    logic [31:0]  qa[$];
    logic [127:0] qd[$];
    logic [31:0]  m_base;
    int           m_line;
    logic [31:0]  m_buf[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (word_ready) ready_seen = 1'b1;
        if (done_o) begin
            chk("done_1cyc", 128'(prev_done), 128'(0));
            done_cnt++;
        end
        prev_done = done_o;
        if (isa_wren_o) begin
            wren_cnt++;
            wren_cyc_q.push_back(cyc);
            if (qd.size() == 0) begin
                chk("unexp_wren", 128'(1), 128'(0));
            end else begin
                chk("wr_addr", 128'(isa_addr_o), 128'(qa.pop_front()));
                chk("wr_data", isa_data_o, qd.pop_front());
            end
        end else begin
            chk("idle_addr", 128'(isa_addr_o), 128'(0));
            chk("idle_data", isa_data_o, 128'(0));
        end
    end

    // Reference model: lines are groups of four accepted words.
    task automatic m_start(input logic [31:0] b);
        m_base = b;
        m_line = 0;
        m_buf.delete();
    endtask

    task automatic m_word(input logic [31:0] w);
        m_buf.push_back(w);
        if (m_buf.size() == 4) begin
            qa.push_back(m_base + 32'(m_line));
            qd.push_back({m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
            m_line++;
            m_buf.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rnd_full) isa_full_i = 1'($urandom_range(0, 1));
    endtask

    task automatic start(input logic [31:0] b, input logic [15:0] l);
        cfg_base_addr = b;
        cfg_len       = l;
        cfg_start     = 1'b1;
        tick();
        cfg_start     = 1'b0;
        m_start(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        logic r;
        bit   acc;
        acc = 1'b0;
        word_valid = 1'b0;
        repeat (gap) tick();
        word_valid = 1'b1;
        word_data  = w;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            r = word_ready;
            tick();
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        word_valid = 1'b0;
        if (acc) begin
            m_word(w);
            acc_cyc = cyc;
        end else begin
            chk("word_timeout", 128'(0), 128'(1));
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 128'(ok), 128'(1));
        if (ok) begin
            chk("done_cnt", 128'(done_cnt - d0), 128'(1));
            chk("busy_fall", 128'(busy_o), 128'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, acc4, acc8, mark, tot;
        logic [15:0] len;

        // Reset state
        #12;
        chk("rst_wren", 128'(isa_wren_o), 128'(0));
        chk("rst_data", isa_data_o, 128'(0));
        chk("rst_addr", 128'(isa_addr_o), 128'(0));
        chk("rst_busy", 128'(busy_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_ready", 128'(word_ready), 128'(0));
        @(posedge clk_i);
        #1;
        rstn = 1'b1;
        tick();

        // Basic load, with a stray start while busy
        w0 = wren_cnt; d0 = done_cnt; wren_cyc_q.delete();
        acc4 = 0; acc8 = 0;
        start(32'h100, 16'd2);
        for (int k = 1; k <= 8; k++) begin
            send_word(32'h11111111 * 32'(k), 0);
            if (k == 4) acc4 = acc_cyc;
            if (k == 8) acc8 = acc_cyc;
            if (k == 1) begin
                cfg_base_addr = 32'h999; cfg_len = 16'd5; cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
            end
        end
        wait_done(d0, 50);
        chk("basic_wrens", 128'(wren_cnt - w0), 128'(2));
        chk("basic_q", 128'(qd.size()), 128'(0));
        if (wren_cyc_q.size() == 2) begin
            chk("basic_lat1", 128'(wren_cyc_q[0]), 128'(acc4 + 1));
            chk("basic_lat2", 128'(wren_cyc_q[1]), 128'(acc8 + 1));
        end else begin
            chk("basic_lat_cnt", 128'(wren_cyc_q.size()), 128'(2));
        end

        // Backpressure
        w0 = wren_cnt; d0 = done_cnt; wren_cyc_q.delete();
        isa_full_i = 1'b1;
        start(32'h200, 16'd1);
        for (int k = 0; k < 4; k++) send_word($urandom, 0);
        repeat (10) tick();
        chk("bp_hold", 128'(wren_cnt - w0), 128'(0));
        isa_full_i = 1'b0;
        mark = cyc;
        wait_done(d0, 20);
        chk("bp_wrens", 128'(wren_cnt - w0), 128'(1));
        if (wren_cyc_q.size() == 1) chk("bp_lat", 128'(wren_cyc_q[0]), 128'(mark + 1));
        else chk("bp_lat_cnt", 128'(wren_cyc_q.size()), 128'(1));

        // Gapped input
        w0 = wren_cnt; d0 = done_cnt;
        start(32'h300, 16'd1);
        send_word(32'hA0A0A0A0, 0);
        send_word(32'hB1B1B1B1, 0);
        send_word(32'hC2C2C2C2, 3);
        chk("gap_early", 128'(wren_cnt - w0), 128'(0));
        send_word(32'hD3D3D3D3, 0);
        wait_done(d0, 20);
        chk("gap_wrens", 128'(wren_cnt - w0), 128'(1));

        // Zero length
        w0 = wren_cnt; d0 = done_cnt; ready_seen = 1'b0;
        start(32'h400, 16'd0);
        wait_done(d0, 2);
        chk("zero_wrens", 128'(wren_cnt - w0), 128'(0));
        chk("zero_ready", 128'(ready_seen), 128'(0));

        // Abort after two words, then abort+start together while idle
        w0 = wren_cnt; d0 = done_cnt;
        start(32'h500, 16'd3);
        send_word(32'hDEAD0001, 0);
        send_word(32'hDEAD0002, 0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        m_buf.delete();
        repeat (3) tick();
        chk("abort_busy", 128'(busy_o), 128'(0));
        chk("abort_wren", 128'(wren_cnt - w0), 128'(0));
        chk("abort_done", 128'(done_cnt - d0), 128'(0));
        cfg_base_addr = 32'h700; cfg_len = 16'd1; cfg_start = 1'b1; cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        tick();
        chk("abort_start_idle", 128'(busy_o), 128'(0));
        start(32'h20, 16'd1);
        for (int k = 0; k < 4; k++) send_word(32'h5A000000 + 32'(k), 0);
        wait_done(d0, 20);
        chk("abort_new_wren", 128'(wren_cnt - w0), 128'(1));
        chk("abort_q", 128'(qd.size()), 128'(0));

        // Address wrap
        w0 = wren_cnt; d0 = done_cnt;
        start(32'hFFFFFFFF, 16'd2);
        for (int k = 0; k < 8; k++) send_word($urandom, 0);
        wait_done(d0, 30);
        chk("wrap_wrens", 128'(wren_cnt - w0), 128'(2));
        chk("wrap_q", 128'(qd.size()), 128'(0));

        // Asynchronous reset mid-collect
        start(32'h600, 16'd2);
        send_word(32'h01234567, 0);
        send_word(32'h89ABCDEF, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", 128'(busy_o), 128'(0));
        chk("arst_ready", 128'(word_ready), 128'(0));
        chk("arst_wren", 128'(isa_wren_o), 128'(0));
        chk("arst_data", isa_data_o, 128'(0));
        chk("arst_addr", 128'(isa_addr_o), 128'(0));
        chk("arst_done", 128'(done_o), 128'(0));
        m_buf.delete(); qa.delete(); qd.delete();
        @(posedge clk_i);
        #1;
        rstn = 1'b1;
        tick();

        // Randomized loads with random gaps and random backpressure
        w0 = wren_cnt; tot = 0;
        rnd_full = 1'b1;
        for (int t = 0; t < 15; t++) begin
            d0  = done_cnt;
            len = 16'($urandom_range(1, 3));
            tot += int'(len);
            start($urandom, len);
            for (int k = 0; k < 4 * int'(len); k++) send_word($urandom, $urandom_range(0, 2));
            wait_done(d0, 400);
        end
        rnd_full = 1'b0;
        isa_full_i = 1'b0;
        tick();
        chk("rnd_wrens", 128'(wren_cnt - w0), 128'(tot));
        chk("rnd_q", 128'(qd.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
